// File: rtl/dds_phase_acc.sv
// rtl/dds_phase_acc.sv - DDS phase accumulator with shadowed FTW/POW and wrap-synchronous commit
module dds_phase_acc #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_addr,
    input  logic [ACC_W-1:0]   cfg_data,
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_valid,
    output logic               wrap,
    output logic               running
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_FTW  = 2'd0;
    localparam logic [1:0] ADDR_POW  = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ftw_sh_q, ftw_sh_d;
    logic [ACC_W-1:0]   ftw_act_q, ftw_act_d;
    logic [PHASE_W-1:0] pow_sh_q, pow_sh_d;
    logic [PHASE_W-1:0] pow_act_q, pow_act_d;
    logic [PHASE_W-1:0] phase_out_q, phase_out_d;
    logic               phase_valid_q, phase_valid_d;
    logic               wrap_q, wrap_d;
    logic               carry_q, carry_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               running_q, running_d;

    logic               cfg_fire;
    logic               ctrl_wr;
    logic               c_run, c_commit, c_sync, c_clear;
    logic               defer;
    logic               advancing;
    logic               carry;
    logic [ACC_W-1:0]   acc_sum;

    always_comb begin
        cfg_fire  = cfg_valid & cfg_ready_q;
        ctrl_wr   = cfg_fire && (cfg_addr == ADDR_CTRL);
        c_run     = cfg_data[0];
        c_commit  = cfg_data[1];
        c_sync    = cfg_data[2];
        c_clear   = cfg_data[3];
        advancing = (state_q != ST_STOP);
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, ftw_act_q};

        // Sync commit is only meaningful when the accumulator will actually wrap.
        defer = c_run & c_commit & c_sync & ~c_clear
              & (state_q != ST_STOP) & (ftw_act_q != '0);

        state_d       = state_q;
        acc_d         = acc_q;
        ftw_sh_d      = ftw_sh_q;
        ftw_act_d     = ftw_act_q;
        pow_sh_d      = pow_sh_q;
        pow_act_d     = pow_act_q;
        phase_out_d   = phase_out_q;
        phase_valid_d = 1'b0;
        wrap_d        = 1'b0;
        carry_d       = carry_q;

        if (cfg_fire && (cfg_addr == ADDR_FTW)) begin
            ftw_sh_d = cfg_data;
        end
        if (cfg_fire && (cfg_addr == ADDR_POW)) begin
            pow_sh_d = cfg_data[PHASE_W-1:0];
        end

        if (advancing) begin
            acc_d         = acc_sum;
            carry_d       = carry;
            phase_out_d   = acc_q[ACC_W-1 -: PHASE_W] + pow_act_q;
            phase_valid_d = 1'b1;
            wrap_d        = carry_q;
        end

        // This addition still uses the old FTW; the new one applies from the next cycle.
        if ((state_q == ST_PEND) && carry) begin
            ftw_act_d = ftw_sh_q;
            pow_act_d = pow_sh_q;
            state_d   = ST_RUN;
        end

        if (ctrl_wr) begin
            if (!c_run) begin
                state_d = ST_STOP;
            end else if (defer) begin
                state_d = ST_PEND;
            end else begin
                state_d = ST_RUN;
            end
            if (c_commit && !defer) begin
                ftw_act_d = ftw_sh_q;
                pow_act_d = pow_sh_q;
            end
            if (c_clear) begin
                acc_d   = '0;
                carry_d = 1'b0;
            end
        end

        cfg_ready_d = (state_d != ST_PEND);
        running_d   = (state_d != ST_STOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_STOP;
            acc_q         <= '0;
            ftw_sh_q      <= '0;
            ftw_act_q     <= '0;
            pow_sh_q      <= '0;
            pow_act_q     <= '0;
            phase_out_q   <= '0;
            phase_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
            carry_q       <= 1'b0;
            cfg_ready_q   <= 1'b1;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            ftw_sh_q      <= ftw_sh_d;
            ftw_act_q     <= ftw_act_d;
            pow_sh_q      <= pow_sh_d;
            pow_act_q     <= pow_act_d;
            phase_out_q   <= phase_out_d;
            phase_valid_q <= phase_valid_d;
            wrap_q        <= wrap_d;
            carry_q       <= carry_d;
            cfg_ready_q   <= cfg_ready_d;
            running_q     <= running_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign phase_out   = phase_out_q;
    assign phase_valid = phase_valid_q;
    assign wrap        = wrap_q;
    assign running     = running_q;

endmodule

// File: tb/tb_dds_phase_acc.sv
// tb/tb_dds_phase_acc.sv - directed self-checking bench for dds_phase_acc
module tb_dds_phase_acc;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [7:0]  phase_out;
    logic        phase_valid;
    logic        wrap;
    logic        running;

    int n_checks = 0;
    int n_pass   = 0;

    dds_phase_acc #(.ACC_W(32), .PHASE_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .phase_out   (phase_out),
        .phase_valid (phase_valid),
        .wrap        (wrap),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        int n;
        n = 0;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) chk("cfg_ready_timeout", {31'd0, cfg_ready}, 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_phase(input logic [7:0] v);
        int n;
        n = 0;
        while (phase_out !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_phase", {24'd0, phase_out}, {24'd0, v});
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = 2'd0;
        cfg_data  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_phase", {24'd0, phase_out}, 32'h00);
        chk("rst_valid", {31'd0, phase_valid}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_running", {31'd0, running}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Step 1: full phase sweep with one wrap.
        cfg_write(2'd0, 32'h0100_0000);
        cfg_write(2'd1, 32'h0000_0000);
        cfg_write(2'd2, 32'h0000_0003);
        chk("t1_running", {31'd0, running}, 32'd1);
        chk("t1_valid_first", {31'd0, phase_valid}, 32'd0);
        @(negedge clk);
        for (int i = 0; i <= 256; i++) begin
            if (i > 0) @(negedge clk);
            chk("t1_phase", {24'd0, phase_out}, {24'd0, i[7:0]});
            chk("t1_wrap", {31'd0, wrap}, {31'd0, (i == 256)});
            chk("t1_valid", {31'd0, phase_valid}, 32'd1);
        end

        // Sync commit to step 4 at the next wrap.
        cfg_write(2'd0, 32'h0400_0000);
        chk("t2_shadow_only", {24'd0, phase_out}, 32'h01);
        wait_phase(8'h3F);
        cfg_write(2'd2, 32'h0000_0007);
        chk("t2_phase_accept", {24'd0, phase_out}, 32'h40);
        chk("t2_ready_low", {31'd0, cfg_ready}, 32'd0);
        chk("t2_running", {31'd0, running}, 32'd1);
        for (int p = 8'h41; p <= 8'hFF; p++) begin
            @(negedge clk);
            chk("t2_phase", {24'd0, phase_out}, p);
            chk("t2_ready", {31'd0, cfg_ready}, {31'd0, (p == 8'hFF)});
        end
        @(negedge clk);
        chk("t2_wrap_phase", {24'd0, phase_out}, 32'h00);
        chk("t2_wrap", {31'd0, wrap}, 32'd1);
        @(negedge clk);
        chk("t2_step4_a", {24'd0, phase_out}, 32'h04);
        chk("t2_wrap_off", {31'd0, wrap}, 32'd0);
        @(negedge clk);
        chk("t2_step4_b", {24'd0, phase_out}, 32'h08);

        // Commit with clear and a new POW.
        cfg_write(2'd0, 32'h0100_0000);
        cfg_write(2'd1, 32'h0000_0080);
        chk("t3_pow_shadow", {24'd0, phase_out}, 32'h10);
        cfg_write(2'd2, 32'h0000_000B);
        chk("t3_accept_phase", {24'd0, phase_out}, 32'h14);
        chk("t3_ready", {31'd0, cfg_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_phase", {24'd0, phase_out}, 32'h80 + i);
        end

        // Stop and resume without discontinuity.
        wait_phase(8'h36);
        cfg_write(2'd2, 32'h0000_0000);
        chk("t4_stop_phase", {24'd0, phase_out}, 32'h37);
        chk("t4_stop_valid_k", {31'd0, phase_valid}, 32'd1);
        chk("t4_running", {31'd0, running}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_phase", {24'd0, phase_out}, 32'h37);
            chk("t4_hold_valid", {31'd0, phase_valid}, 32'd0);
            chk("t4_hold_wrap", {31'd0, wrap}, 32'd0);
        end
        cfg_write(2'd2, 32'h0000_0001);
        chk("t4_resume_valid_k", {31'd0, phase_valid}, 32'd0);
        chk("t4_resume_phase_k", {24'd0, phase_out}, 32'h37);
        @(negedge clk);
        chk("t4_resume_a", {24'd0, phase_out}, 32'h38);
        chk("t4_resume_valid", {31'd0, phase_valid}, 32'd1);
        @(negedge clk);
        chk("t4_resume_b", {24'd0, phase_out}, 32'h39);

        // Active FTW zero: sync request commits immediately.
        cfg_write(2'd0, 32'h0000_0000);
        cfg_write(2'd2, 32'h0000_0003);
        chk("t5_zero_commit", {24'd0, phase_out}, 32'h3B);
        cfg_write(2'd0, 32'h0200_0000);
        chk("t5_frozen", {24'd0, phase_out}, 32'h3C);
        cfg_write(2'd2, 32'h0000_0007);
        chk("t5_ready", {31'd0, cfg_ready}, 32'd1);
        chk("t5_running", {31'd0, running}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_phase", {24'd0, phase_out}, 32'h3C + 2 * i);
            chk("t5_ready_hold", {31'd0, cfg_ready}, 32'd1);
        end

        // Reset during PEND.
        cfg_write(2'd0, 32'h0100_0000);
        cfg_write(2'd2, 32'h0000_0007);
        chk("t6_pend_ready", {31'd0, cfg_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_phase", {24'd0, phase_out}, 32'h00);
        chk("t6_async_valid", {31'd0, phase_valid}, 32'd0);
        chk("t6_async_wrap", {31'd0, wrap}, 32'd0);
        chk("t6_async_ready", {31'd0, cfg_ready}, 32'd1);
        chk("t6_async_running", {31'd0, running}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_running", {31'd0, running}, 32'd0);
        cfg_write(2'd3, 32'h0000_000F);
        chk("t6_reserved", {31'd0, running}, 32'd0);
        cfg_write(2'd2, 32'h0000_0001);
        chk("t6_run", {31'd0, running}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_ftw0_phase", {24'd0, phase_out}, 32'h00);
            chk("t6_ftw0_valid", {31'd0, phase_valid}, 32'd1);
            chk("t6_ftw0_ready", {31'd0, cfg_ready}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
